alarm_snooze_controller: RTL and testbench
==========================================

# alarm_snooze_controller

Sequences the alarm once the time and alarm counters agree: arms the alarm, gates the buzzer while ringing, runs a snooze countdown with a bounded number of snoozes, auto-silences after a ring timeout, and re-arms only after the matching minute has passed. It sits between the master controller, which supplies the enable and time-equals-alarm match, and the alarm-on blinker. It runs in the 5 MHz domain, advancing its timers on the 1 Hz pulse.

## Interface
- SNOOZE_SECONDS, 540: snooze length in seconds; legal range 1..65535.
- RING_TIMEOUT_SECONDS, 60: maximum continuous ring time in seconds; legal range 1..65535.
- MAX_SNOOZES, 3: snoozes allowed per alarm event; legal range 0..7.

- i_Clk  in  1  block clock (5 MHz domain).
- i_Reset  in  1  reset; asynchronous, active-high.
- i_Sec_Pulse  in  1  one-cycle pulse, once per second.
- i_Alarm_Enable  in  1  level; alarm feature enabled.
- i_Alarm_Match  in  1  level; current time hours/minutes equal alarm hours/minutes.
- i_Snooze_Pulse  in  1  one-cycle debounced snooze request.
- i_Dismiss_Pulse  in  1  one-cycle debounced dismiss request.
- o_Alarm_On  out  1  buzzer/blink gate; high only in RINGING.
- o_State  out  3  current state encoding, for debug and display.
- o_Snooze_Count  out  3  snoozes used in the current alarm event.
- o_Snooze_Remaining  out  16  seconds left in the snooze; 0 outside SNOOZING.

## Operation
- States, with their `o_State` encoding: DISABLED=0, WAIT_CLEAR=1, ARMED=2, RINGING=3, SNOOZING=4. Encodings 5..7 are illegal and recover to DISABLED on the next cycle.
- Global rule: `i_Alarm_Enable` low in any state -> DISABLED on the next clock. This rule has priority over every other transition. On entry to DISABLED, the timer and snooze count clear.
- DISABLED: enable high -> WAIT_CLEAR. The alarm never rings in a minute that was already matching when it was enabled.
- WAIT_CLEAR: `i_Alarm_Match` low -> ARMED. On entry, the snooze count and timer are 0.
- ARMED: match high -> RINGING; timer loads RING_TIMEOUT_SECONDS.
- RINGING, with priorities highest first:
  - Dismiss -> WAIT_CLEAR.
  - Snooze with count < MAX_SNOOZES -> SNOOZING; count +1; timer loads SNOOZE_SECONDS.
  - Snooze with count == MAX_SNOOZES -> ignored; stay ringing.
  - `i_Sec_Pulse` with timer == 1 (timeout): if count < MAX_SNOOZES, behave as a snooze. Otherwise -> WAIT_CLEAR.
  - `i_Sec_Pulse` otherwise: timer -1.
- SNOOZING, with priorities highest first:
  - Dismiss -> WAIT_CLEAR.
  - Snooze -> ignored.
  - `i_Sec_Pulse` with timer == 1 -> RINGING; timer loads RING_TIMEOUT_SECONDS.
  - `i_Sec_Pulse` otherwise: timer -1.
  - `i_Alarm_Match` is ignored.
- Simultaneous snooze/dismiss with `i_Sec_Pulse`: the request wins and the pulse is discarded for that cycle.
- Arithmetic:
  - The timer is 16-bit unsigned and never decrements below 1 in SNOOZING or RINGING.
  - The count is 3-bit and saturates at MAX_SNOOZES.
- MAX_SNOOZES = 0: every snooze request is ignored, and timeout goes to WAIT_CLEAR.

## Timing
- Reset values: state DISABLED, all outputs 0.
- Reset asserted mid-ring or mid-snooze clears everything immediately, asynchronously. On release, the block restarts from DISABLED.
- All outputs are decoded from registers only; there is no combinational input-to-output path.
- An input sampled at edge N is reflected on the outputs after edge N:
  - Match high at edge N -> `o_Alarm_On` high after edge N.
  - Snooze at edge N -> `o_Alarm_On` low and `o_Snooze_Remaining` = SNOOZE_SECONDS after edge N.
- Ring duration: exactly RING_TIMEOUT_SECONDS `i_Sec_Pulse` events after entry to RINGING, counting the pulse that causes the exit.
- Snooze duration: exactly SNOOZE_SECONDS `i_Sec_Pulse` events after entry to SNOOZING.
- `o_Snooze_Remaining` tracks the timer in SNOOZING and reads 0 in all other states.

## Test plan
Parameters for all scenarios: SNOOZE_SECONDS=5, RING_TIMEOUT_SECONDS=3, MAX_SNOOZES=2.

1. Enable with match low, then raise match -> states 1 -> 2 -> 3 and `o_Alarm_On` = 1 one cycle after match. Dismiss -> state 1 and `o_Alarm_On` = 0. Drop match -> state 2.
2. Ring, then snooze -> state 4, `o_Snooze_Remaining` = 5, count = 1. After 5 sec pulses -> state 3. Snooze again -> count = 2. A third snooze after re-ring is ignored (state stays 3). After 3 sec pulses -> state 1.
3. Ring with no input -> auto-snooze after the 3rd sec pulse (count 1). A further 5 pulses re-ring, and a further 3 auto-snooze (count 2). After the final 3 pulses -> state 1.
4. Enable while match is already high -> state stays 1 with `o_Alarm_On` = 0. Match low -> 2. Match high -> 3.
5. Snooze and sec pulse in the same cycle while ringing (timer = 1) -> state 4 with remaining = 5 and count +1 exactly once. Dismiss and snooze in the same cycle -> state 1.
6. Assert `i_Reset`, and separately drop `i_Alarm_Enable`, during SNOOZING -> state 0 and all outputs 0: asynchronously for reset, on the next clock for enable.

Source files
------------

// File: rtl/alarm_snooze_controller.sv
// alarm_snooze_controller: arms, rings, snoozes and auto-silences the alarm on time/alarm match
module alarm_snooze_controller #(
  parameter int SNOOZE_SECONDS       = 540,
  parameter int RING_TIMEOUT_SECONDS = 60,
  parameter int MAX_SNOOZES          = 3
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Sec_Pulse,
  input  logic        i_Alarm_Enable,
  input  logic        i_Alarm_Match,
  input  logic        i_Snooze_Pulse,
  input  logic        i_Dismiss_Pulse,
  output logic        o_Alarm_On,
  output logic [2:0]  o_State,
  output logic [2:0]  o_Snooze_Count,
  output logic [15:0] o_Snooze_Remaining
);
  typedef enum logic [2:0] {
    DISABLED   = 3'd0,
    WAIT_CLEAR = 3'd1,
    ARMED      = 3'd2,
    RINGING    = 3'd3,
    SNOOZING   = 3'd4
  } state_t;
  localparam logic [15:0] SNOOZE_T = 16'(SNOOZE_SECONDS);
  localparam logic [15:0] RING_T   = 16'(RING_TIMEOUT_SECONDS);
  localparam logic [2:0]  MAX_C    = 3'(MAX_SNOOZES);
  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  count_q, count_d;
  logic        alarm_on_q, alarm_on_d;
  logic [15:0] remaining_q, remaining_d;
  logic        snooze_ok, expire;
  // next state: enable has top priority, requests beat the second pulse, timer stops at 1
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    count_d   = count_q;
    snooze_ok = count_q < MAX_C;
    expire    = i_Sec_Pulse && timer_q == 16'd1;
    if (!i_Alarm_Enable) begin
      state_d = DISABLED;
      timer_d = '0;
      count_d = '0;
    end else begin
      case (state_q)
        DISABLED: state_d = WAIT_CLEAR;
        WAIT_CLEAR: state_d = i_Alarm_Match ? WAIT_CLEAR : ARMED;
        ARMED: if (i_Alarm_Match) begin
          state_d = RINGING;
          timer_d = RING_T;
        end
        RINGING: if (i_Dismiss_Pulse || (expire && !i_Snooze_Pulse && !snooze_ok)) begin
          state_d = WAIT_CLEAR;
          timer_d = '0;
          count_d = '0;
        end else if ((i_Snooze_Pulse || expire) && snooze_ok) begin
          state_d = SNOOZING;
          timer_d = SNOOZE_T;
          count_d = count_q + 3'd1;
        end else if (i_Sec_Pulse && !i_Snooze_Pulse) begin
          timer_d = timer_q - 16'd1;
        end
        SNOOZING: if (i_Dismiss_Pulse) begin
          state_d = WAIT_CLEAR;
          timer_d = '0;
          count_d = '0;
        end else if (expire && !i_Snooze_Pulse) begin
          state_d = RINGING;
          timer_d = RING_T;
        end else if (i_Sec_Pulse && !i_Snooze_Pulse) begin
          timer_d = timer_q - 16'd1;
        end
        default: begin
          state_d = DISABLED;
          timer_d = '0;
          count_d = '0;
        end
      endcase
    end
    alarm_on_d  = state_d == RINGING;
    remaining_d = state_d == SNOOZING ? timer_d : 16'd0;
  end
  // state, timers and registered outputs
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q     <= DISABLED;
      timer_q     <= '0;
      count_q     <= '0;
      alarm_on_q  <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
      alarm_on_q  <= alarm_on_d;
      remaining_q <= remaining_d;
    end
  end
  assign o_Alarm_On         = alarm_on_q;
  assign o_State            = state_q;
  assign o_Snooze_Count     = count_q;
  assign o_Snooze_Remaining = remaining_q;
endmodule

// File: tb/tb_alarm_snooze_controller.sv
// tb_alarm_snooze_controller: directed plan plus random stimulus against an event-counting model
module tb_alarm_snooze_controller;
  localparam int SNZ = 5;
  localparam int RING = 3;
  localparam int MAXS = 2;
  logic        i_Clk = 1'b0;
  logic        i_Reset, i_Sec_Pulse, i_Alarm_Enable, i_Alarm_Match, i_Snooze_Pulse, i_Dismiss_Pulse;
  logic        o_Alarm_On;
  logic [2:0]  o_State, o_Snooze_Count;
  logic [15:0] o_Snooze_Remaining;
  int n_checks = 0;
  int n_errors = 0;
  int m_mode, m_cnt, m_rung, m_slept;
  logic rm;

  alarm_snooze_controller #(.SNOOZE_SECONDS(SNZ), .RING_TIMEOUT_SECONDS(RING), .MAX_SNOOZES(MAXS)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Sec_Pulse(i_Sec_Pulse), .i_Alarm_Enable(i_Alarm_Enable),
    .i_Alarm_Match(i_Alarm_Match), .i_Snooze_Pulse(i_Snooze_Pulse), .i_Dismiss_Pulse(i_Dismiss_Pulse),
    .o_Alarm_On(o_Alarm_On), .o_State(o_State), .o_Snooze_Count(o_Snooze_Count),
    .o_Snooze_Remaining(o_Snooze_Remaining)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_rung = 0; m_slept = 0;
  endtask

  task automatic start_snooze();
    m_mode = 4; m_cnt++; m_slept = 0;
  endtask

  // mode: 0 off, 1 waiting for the matching minute to pass, 2 armed, 3 ringing, 4 snoozing
  task automatic model(input logic en, input logic m, input logic s, input logic snz, input logic dis);
    if (!en) model_reset();
    else if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1) begin if (!m) m_mode = 2; end
    else if (m_mode == 2) begin if (m) begin m_mode = 3; m_rung = 0; end end
    else if (m_mode == 3) begin
      if (dis) begin m_mode = 1; m_cnt = 0; end
      else if (snz) begin if (m_cnt < MAXS) start_snooze(); end
      else if (s) begin
        m_rung++;
        if (m_rung == RING) begin
          if (m_cnt < MAXS) start_snooze();
          else begin m_mode = 1; m_cnt = 0; end
        end
      end
    end else begin
      if (dis) begin m_mode = 1; m_cnt = 0; end
      else if (!snz && s) begin
        m_slept++;
        if (m_slept == SNZ) begin m_mode = 3; m_rung = 0; end
      end
    end
  endtask

  task automatic compare_all();
    chk("state", 16'(o_State), 16'(m_mode));
    chk("alarm_on", 16'(o_Alarm_On), 16'(m_mode == 3));
    chk("count", 16'(o_Snooze_Count), 16'(m_cnt));
    chk("remaining", o_Snooze_Remaining, m_mode == 4 ? 16'(SNZ - m_slept) : 16'd0);
  endtask

  task automatic step(input logic en, input logic m, input logic s, input logic snz, input logic dis);
    i_Alarm_Enable = en; i_Alarm_Match = m; i_Sec_Pulse = s; i_Snooze_Pulse = snz; i_Dismiss_Pulse = dis;
    @(posedge i_Clk);
    model(en, m, s, snz, dis);
    #1 compare_all();
    @(negedge i_Clk);
  endtask

  task automatic secs(input logic m, input int n);
    for (int k = 0; k < n; k++) step(1, m, 1, 0, 0);
  endtask

  // reset pulse placed between clock edges so only the asynchronous path can clear the outputs
  task automatic pulse_reset();
    #2 i_Reset = 1'b1;
    #1 model_reset();
    compare_all();
    #1 i_Reset = 1'b0;
  endtask

  initial begin
    i_Reset = 1'b1; i_Sec_Pulse = 0; i_Alarm_Enable = 0; i_Alarm_Match = 0; i_Snooze_Pulse = 0; i_Dismiss_Pulse = 0;
    model_reset();
    repeat (2) @(negedge i_Clk);
    compare_all();
    i_Reset = 1'b0;
    // enable, arm, ring, dismiss, re-arm
    step(1, 0, 0, 0, 0); chk("t1_wait", 16'(o_State), 16'd1);
    step(1, 0, 0, 0, 0); chk("t1_armed", 16'(o_State), 16'd2);
    step(1, 1, 0, 0, 0); chk("t1_ring_on", 16'(o_Alarm_On), 16'd1);
    step(1, 1, 0, 0, 1); chk("t1_dismiss", 16'(o_State), 16'd1);
    step(1, 0, 0, 0, 0); chk("t1_rearm", 16'(o_State), 16'd2);
    // manual snoozes up to the limit
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0); chk("t2_snz_rem", o_Snooze_Remaining, 16'd5);
    secs(1, 4); chk("t2_still_snz", 16'(o_State), 16'd4);
    secs(1, 1); chk("t2_rering", 16'(o_State), 16'd3);
    step(1, 1, 0, 1, 0); chk("t2_cnt2", 16'(o_Snooze_Count), 16'd2);
    secs(1, 5);
    step(1, 1, 0, 1, 0); chk("t2_snz_ignored", 16'(o_State), 16'd3);
    secs(1, 3); chk("t2_timeout", 16'(o_State), 16'd1);
    step(1, 0, 0, 0, 0);
    // unattended ring auto-snoozes until the limit
    step(1, 1, 0, 0, 0);
    secs(1, 3); chk("t3_auto1", 16'(o_Snooze_Count), 16'd1);
    secs(1, 5); secs(1, 3); chk("t3_auto2", 16'(o_Snooze_Count), 16'd2);
    secs(1, 5); secs(1, 3); chk("t3_final", 16'(o_State), 16'd1);
    // enabling inside a matching minute must not ring
    step(0, 1, 0, 0, 0); chk("t4_off", 16'(o_State), 16'd0);
    step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0); chk("t4_no_ring", 16'(o_Alarm_On), 16'd0);
    step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0); chk("t4_ring", 16'(o_State), 16'd3);
    // snooze coincident with the expiring second, then dismiss with snooze
    secs(1, 2);
    step(1, 1, 1, 1, 0); chk("t5_rem", o_Snooze_Remaining, 16'd5); chk("t5_cnt", 16'(o_Snooze_Count), 16'd1);
    step(1, 1, 0, 1, 1); chk("t5_dismiss", 16'(o_State), 16'd1);
    // reset and disable while snoozing
    step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 1, 0);
    pulse_reset(); chk("t6_rst_state", 16'(o_State), 16'd0);
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0); chk("t6_dis_rem", o_Snooze_Remaining, 16'd0);
    // random traffic
    rm = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 9) == 0) rm = ~rm;
      if ($urandom_range(0, 299) == 0) pulse_reset();
      else step($urandom_range(0, 59) != 0, rm, $urandom_range(0, 2) == 0,
                $urandom_range(0, 14) == 0, $urandom_range(0, 29) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
